// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the memory-stage FSM encoding.
// No logic; latency and backpressure do not apply.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Addresses are compared at word granularity, so the link stores only [31:2].
    typedef logic [29:0] waddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memstage_state_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register with coherence snoop; clear beats set in the same cycle.
// Latency: state updates on the next edge, link_hit is combinational; no backpressure.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   nRST,
    input  logic   set,
    input  logic   clr_sc,
    input  logic   sw_hit,
    input  waddr_t addr,
    input  logic   ccinv,
    input  waddr_t ccaddr,
    output logic   link_hit
);

    logic   link_valid;
    waddr_t link_addr;
    logic   clr;

    assign link_hit = link_valid & (link_addr == addr);

    // A store or snoop to the linked word breaks the reservation whether or not it is valid.
    assign clr = clr_sc
               | (sw_hit & (link_addr == addr))
               | (ccinv  & (link_addr == ccaddr));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (clr) begin
            link_valid <= 1'b0;
        end else if (set) begin
            link_valid <= 1'b1;
            link_addr  <= addr;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage controller: issues dcache LW/SW/LL/SC requests, captures load/SC result, owns link and halt.
// Latency: N+2 cycles for an access with N wait cycles, 1 for others; mem_stall holds upstream until dhit.
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  memRd_MEM,
    input  logic  memWr_MEM,
    input  logic  ll_MEM,
    input  logic  sc_MEM,
    input  logic  halt_MEM,
    input  word_t addr_MEM,
    input  word_t busB_MEM,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t rdata_MEM,
    output logic  halt
);

    memstage_state_t state, next_state;

    logic link_hit;
    logic sc_fail;
    logic issue;
    logic req_on;
    logic hit;
    logic sc_fail_done;
    logic unused_ccaddr_lsb;

    assign unused_ccaddr_lsb = ^ccaddr[1:0];

    assign sc_fail = sc_MEM & ~link_hit;
    // Reset gates the request combinationally so an in-flight access drops the moment nRST falls.
    assign issue   = nRST & ~halt & (memRd_MEM | memWr_MEM) & ~sc_fail;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_on     = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    req_on     = 1'b1;
                    next_state = dhit ? DONE : WAIT;
                end
            end
            WAIT: begin
                req_on = nRST;
                if (dhit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Instruction is still in MEM this cycle; stay quiet so it is not reissued.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_stall = req_on;
    assign dmemREN   = req_on & memRd_MEM;
    assign dmemWEN   = req_on & memWr_MEM;
    assign dmemaddr  = addr_MEM;
    assign dmemstore = busB_MEM;

    assign hit          = req_on & dhit;
    assign sc_fail_done = (state == IDLE) & nRST & ~halt & sc_fail;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdata_MEM <= '0;
        end else if (hit & memRd_MEM) begin
            rdata_MEM <= dmemload;
        end else if (hit & sc_MEM) begin
            rdata_MEM <= 32'd1;
        end else if (sc_fail_done) begin
            rdata_MEM <= 32'd0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else if (halt_MEM & ~mem_stall) begin
            halt <= 1'b1;
        end
    end

    link_reg u_link_reg (
        .CLK     (CLK),
        .nRST    (nRST),
        .set     (hit & ll_MEM),
        .clr_sc  ((hit & sc_MEM) | sc_fail_done),
        .sw_hit  (hit & memWr_MEM),
        .addr    (addr_MEM[31:2]),
        .ccinv   (ccinv),
        .ccaddr  (ccaddr[31:2]),
        .link_hit(link_hit)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected rdata pushed per instruction, popped when it leaves MEM.
module tb_memory_stage;

    logic        CLK;
    logic        nRST;
    logic        memRd_MEM, memWr_MEM, ll_MEM, sc_MEM, halt_MEM;
    logic [31:0] addr_MEM, busB_MEM;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ccinv;
    logic [31:0] ccaddr;
    logic        dmemREN, dmemWEN, mem_stall, halt;
    logic [31:0] dmemaddr, dmemstore, rdata_MEM;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb[$];

    // Reference state
    logic        m_lv;
    logic [31:0] m_la;
    logic [31:0] m_rdata;
    logic        m_halt;

    memory_stage dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .memRd_MEM(memRd_MEM),
        .memWr_MEM(memWr_MEM),
        .ll_MEM   (ll_MEM),
        .sc_MEM   (sc_MEM),
        .halt_MEM (halt_MEM),
        .addr_MEM (addr_MEM),
        .busB_MEM (busB_MEM),
        .dhit     (dhit),
        .dmemload (dmemload),
        .ccinv    (ccinv),
        .ccaddr   (ccaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .dmemaddr (dmemaddr),
        .dmemstore(dmemstore),
        .mem_stall(mem_stall),
        .rdata_MEM(rdata_MEM),
        .halt     (halt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_nop();
        memRd_MEM = 1'b0; memWr_MEM = 1'b0; ll_MEM = 1'b0; sc_MEM = 1'b0;
        halt_MEM  = 1'b0; dhit = 1'b0; addr_MEM = '0; busB_MEM = '0;
    endtask

    // Drives one instruction through MEM; dhit rises after `waits` extra request cycles.
    task automatic mem_op(input logic rd, input logic wr, input logic ll, input logic sc,
                          input logic [31:0] addr, input logic [31:0] store,
                          input logic [31:0] load, input int waits, input string tag);
        logic        hitm, exp_req, stall_now;
        logic [31:0] exp_rd;
        int          cyc, nst;
        hitm    = m_lv && (m_la[31:2] == addr[31:2]);
        exp_req = (rd || wr) && !(sc && !hitm) && !m_halt;
        exp_rd  = m_rdata;
        if (exp_req && rd)          exp_rd = load;
        else if (exp_req && sc)     exp_rd = 32'd1;
        else if (sc && !m_halt)     exp_rd = 32'd0;
        m_rdata = exp_rd;
        sb.push_back(exp_rd);
        if (sc && !m_halt) m_lv = 1'b0;
        else if (exp_req && wr && hitm) m_lv = 1'b0;
        else if (exp_req && ll) begin m_lv = 1'b1; m_la = addr; end

        memRd_MEM = rd; memWr_MEM = wr; ll_MEM = ll; sc_MEM = sc;
        addr_MEM = addr; busB_MEM = store; dmemload = load;
        dhit = (waits == 0);
        cyc = 0; nst = 0;
        while (1) begin
            @(negedge CLK);
            stall_now = mem_stall;
            if (stall_now) nst++;
            if (cyc == 0) begin
                check({tag, "_ren"}, {31'd0, dmemREN}, {31'd0, exp_req && rd});
                check({tag, "_wen"}, {31'd0, dmemWEN}, {31'd0, exp_req && wr});
                if (exp_req) begin
                    check({tag, "_addr"},  dmemaddr,  addr);
                    check({tag, "_store"}, dmemstore, store);
                end
            end else if (!stall_now) begin
                check({tag, "_done_noreq"}, {31'd0, dmemREN | dmemWEN}, 32'd0);
            end
            @(posedge CLK); #1;
            cyc++;
            if (!stall_now || cyc > 40) break;
            dhit = (cyc == waits);
        end
        drive_nop();
        check({tag, "_cycles"}, cyc, exp_req ? waits + 2 : 1);
        check({tag, "_stalls"}, nst, exp_req ? waits + 1 : 0);
        if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else check({tag, "_rdata"}, rdata_MEM, sb.pop_front());
    endtask

    task automatic snoop(input logic [31:0] a);
        ccinv = 1'b1; ccaddr = a;
        @(posedge CLK); #1;
        ccinv = 1'b0;
        if (m_lv && m_la[31:2] == a[31:2]) m_lv = 1'b0;
    endtask

    initial begin
        drive_nop();
        dmemload = '0; ccinv = 1'b0; ccaddr = '0;
        m_lv = 1'b0; m_la = '0; m_rdata = '0; m_halt = 1'b0;
        nRST = 1'b0;
        #23;
        check("rst_rdata", rdata_MEM, 32'd0);
        check("rst_halt",  {31'd0, halt}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_req",   {31'd0, dmemREN | dmemWEN}, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        mem_op(1, 0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, "lw100");
        mem_op(0, 1, 0, 0, 32'h200, 32'h12345678, 32'h0,        0, "sw200");
        mem_op(1, 0, 1, 0, 32'h300, 32'h0,        32'hAAAA0001, 1, "ll300");
        mem_op(0, 1, 0, 1, 32'h300, 32'h5,        32'h0,        0, "sc300_ok");
        mem_op(0, 1, 0, 1, 32'h300, 32'h6,        32'h0,        0, "sc300_fail");
        mem_op(1, 0, 1, 0, 32'h300, 32'h0,        32'h11110000, 0, "ll300_b");
        snoop(32'h300);
        mem_op(0, 1, 0, 1, 32'h300, 32'h7,        32'h0,        0, "sc_inv");
        mem_op(1, 0, 1, 0, 32'h300, 32'h0,        32'h22220000, 0, "ll300_c");
        snoop(32'h304);
        mem_op(0, 1, 0, 1, 32'h300, 32'h8,        32'h0,        1, "sc_other_inv");
        mem_op(1, 0, 1, 0, 32'h400, 32'h0,        32'h33330000, 0, "ll400");
        mem_op(0, 1, 0, 0, 32'h402, 32'h9,        32'h0,        0, "sw400");
        mem_op(0, 1, 0, 1, 32'h400, 32'hA,        32'h0,        0, "sc_after_sw");
        mem_op(1, 0, 0, 0, 32'h500, 32'h0,        32'hCAFEF00D, 3, "lw500");

        // Reset in the middle of a waiting load
        memRd_MEM = 1'b1; addr_MEM = 32'h600; dhit = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("wait_stall", {31'd0, mem_stall}, 32'd1);
        check("wait_ren",   {31'd0, dmemREN},   32'd1);
        nRST = 1'b0;
        #1;
        check("midrst_ren",   {31'd0, dmemREN},   32'd0);
        check("midrst_wen",   {31'd0, dmemWEN},   32'd0);
        check("midrst_stall", {31'd0, mem_stall}, 32'd0);
        check("midrst_rdata", rdata_MEM,          32'd0);
        drive_nop();
        m_lv = 1'b0; m_la = '0; m_rdata = '0; m_halt = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        mem_op(1, 0, 0, 0, 32'h700, 32'h0, 32'h0BADCAFE, 0, "lw700");

        // HALT, then a load that must not issue
        halt_MEM = 1'b1;
        @(negedge CLK);
        check("halt_before", {31'd0, halt}, 32'd0);
        @(posedge CLK); #1;
        halt_MEM = 1'b0;
        m_halt = 1'b1;
        check("halt_set", {31'd0, halt}, 32'd1);
        mem_op(1, 0, 0, 0, 32'h800, 32'h0, 32'h55555555, 0, "lw_halted");
        check("halt_held", {31'd0, halt}, 32'd1);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage controller between the EX/MEM latch and the `memory_wb` latch. Issues data-cache read/write requests for LW/SW/LL/SC, holds the pipeline via `mem_stall` until `dhit`, and captures load data (or the SC result) for the `memory_wb` latch. It also owns the LL/SC link register and the sticky halt flag.

## Interface
Parameters:
- None. All data and address widths are `word_t` (32 bits) from `cpu_types_pkg`.

Ports:
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `memRd_MEM`  in  1  instruction in MEM is LW.
- `memWr_MEM`  in  1  instruction in MEM is SW.
- `ll_MEM`  in  1  instruction in MEM is LL. `memRd_MEM` is also set.
- `sc_MEM`  in  1  instruction in MEM is SC. `memWr_MEM` is also set.
- `halt_MEM`  in  1  instruction in MEM is HALT.
- `addr_MEM`  in  32  ALU result, used as the byte address.
- `busB_MEM`  in  32  store data.
- `dhit`  in  1  cache completed the current request this cycle.
- `dmemload`  in  32  read data; valid when `dhit`.
- `ccinv`  in  1  coherence invalidate for `ccaddr`.
- `ccaddr`  in  32  invalidated address.
- `dmemREN`  out  1  read request.
- `dmemWEN`  out  1  write request.
- `dmemaddr`  out  32  `addr_MEM`.
- `dmemstore`  out  32  `busB_MEM`.
- `mem_stall`  out  1  freezes the IF…EX/MEM latches and deasserts `memory_wb` enable.
- `rdata_MEM`  out  32  load data or SC result, registered, to the `memory_wb` latch.
- `halt`  out  1  sticky halt.

## Operation
- Decode: `req = memRd_MEM | memWr_MEM`. `sc_ok = sc_MEM & link_valid & (link_addr == addr_MEM)`.
- An SC with `!sc_ok` issues no memory request.
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - If `req` and not a failing SC: assert `dmemREN` (when `memRd_MEM`) or `dmemWEN` (when `memWr_MEM`) combinationally, and assert `mem_stall`.
  - If `dhit` in the same cycle, go to DONE; otherwise go to WAIT.
  - With no request, or a failing SC: `mem_stall = 0`. A failing SC loads `rdata_MEM <= 0`.
- WAIT: hold the request and `mem_stall = 1`. On `dhit`, go to DONE.
- DONE: no request and `mem_stall = 0`, so the latches advance this edge. Next state is IDLE.
  - The one-cycle DONE state guarantees the same instruction is never reissued.
- Data capture on `dhit`:
  - Read: `rdata_MEM <= dmemload`.
  - Successful SC: `rdata_MEM <= 32'd1`.
  - Plain SW: `rdata_MEM` is unchanged.
- Link register (`link_valid`, `link_addr`):
  - LL `dhit` sets `link_valid = 1` and `link_addr = addr_MEM`.
  - Cleared on any SC completion (success or fail).
  - Cleared on a SW `dhit` to `link_addr`.
  - Cleared on `ccinv` with `ccaddr == link_addr`.
  - If a set and a clear happen in the same cycle, clear wins.
- Address comparisons use `addr[31:2]`, i.e. word granularity.
- `halt`: set when `halt_MEM` is high while `mem_stall == 0`. It stays set until reset. Once `halt` is 1, no new requests are issued.
- `dhit` while no request is outstanding is ignored.

## Timing
- Reset (async, immediate):
  - FSM goes to IDLE.
  - `rdata_MEM = 0`, `link_valid = 0`, `link_addr = 0`, `halt = 0`.
  - Requests deassert in the same cycle `nRST` falls, including a mid-WAIT access.
- Memory instruction with `dhit` at first request cycle: 2 cycles in MEM (IDLE, DONE).
- With N wait cycles: N+2 cycles.
- Non-memory instruction: 1 cycle, `mem_stall = 0`.
- `rdata_MEM` is valid from the DONE cycle onward. It is captured by `memory_wb` at the end of DONE.
- `dmemaddr` and `dmemstore` are combinational passthroughs. They are stable while stalled because the EX/MEM latch is frozen.

## Structure
- `cpu_types_pkg` holds `word_t` and a new `memstage_state_t` enum (IDLE, WAIT, DONE).
- The link register is a natural sub-module, `link_reg`: set, clear, and snoop compare, about 40 lines.
- The FSM and capture logic stay in `memory_stage`.

## Test plan
- LW to 0x100, `dhit` on the 3rd request cycle with `dmemload = 0xDEADBEEF` -> `mem_stall` high for 3 cycles; DONE next; `rdata_MEM = 0xDEADBEEF`; `dmemREN` never high in DONE.
- SW to 0x200 of 0x12345678, `dhit` immediately -> `dmemWEN` for 1 cycle, `dmemstore = 0x12345678`, total 2 cycles.
- LL 0x300, then SC 0x300 -> SC issues a write and `rdata_MEM = 1`. A second SC to 0x300 -> no request, `rdata_MEM = 0`, `mem_stall = 0`.
- LL 0x300, then `ccinv` with `ccaddr = 0x300`, then SC -> SC fails (0). A repeat with `ccaddr = 0x304` -> SC succeeds.
- `nRST` pulsed low mid-WAIT -> `dmemREN`/`dmemWEN` drop immediately, FSM in IDLE, `rdata_MEM = 0`.
- HALT arrives in MEM -> `halt = 1` the next cycle, held through the following LW; no request is issued.
